// File: rtl/uart_loader_pkg.sv
// Shared board-level defaults for the UART program loader, plus the baud divider helper.
package uart_loader_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_UART_BPS = 19_200;
   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_DATA_W   = 32;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: input synchronisers, baud counter, mid-bit sampling FSM and stop-bit check.
// byte_valid_o/frame_err_o are single-cycle strobes coincident with the stop-bit sample.
module uart_rx_core import uart_loader_pkg::*; #(
   parameter int CLK_FREQ    = DEF_CLK_FREQ,
   parameter int BAUD        = DEF_UART_BPS,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       uart_rx_i,
   output logic       en_sync_o,
   output logic       idle_o,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int DIV   = baud_div(CLK_FREQ, BAUD);
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] rx_sync, en_sync;
   logic                   rx, rx_prev;
   logic [CNT_W-1:0]       cnt, cnt_next;
   logic [2:0]             bit_idx, bit_next;
   logic [7:0]             shreg, shreg_next;

   assign rx        = rx_sync[SYNC_STAGES-1];
   assign en_sync_o = en_sync[SYNC_STAGES-1];
   assign idle_o    = (state == IDLE);
   assign byte_o    = shreg;

   // The line idles high, so the rx chain resets to 1 to avoid a false start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync <= '1;
         en_sync <= '0;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rx_i};
         en_sync <= {en_sync[SYNC_STAGES-2:0], en_i};
         rx_prev <= rx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         shreg   <= shreg_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + 1'b1;
      bit_next     = bit_idx;
      shreg_next   = shreg;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      if (!en_sync_o) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_next = '0;
               if (rx_prev && !rx) state_next = START;
            end
            // A start bit that is no longer low at mid-bit is treated as a glitch.
            START: if (cnt == HALF) begin
               cnt_next   = '0;
               bit_next   = '0;
               state_next = rx ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
               cnt_next   = '0;
               shreg_next = {rx, shreg[7:1]};
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
            STOP: if (cnt == FULL) begin
               cnt_next     = '0;
               state_next   = IDLE;
               byte_valid_o = rx;
               frame_err_o  = !rx;
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_loader.sv
// UART program loader: packs received bytes little-endian into words and writes them to
// consecutive addresses from BASE_ADDR over a valid/ready port, with timeout and error flags.
module uart_loader import uart_loader_pkg::*; #(
   parameter int                CLK_FREQ     = DEF_CLK_FREQ,
   parameter int                BAUD         = DEF_UART_BPS,
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter int                DATA_W       = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter int                SYNC_STAGES  = 2,
   parameter int                TIMEOUT_BITS = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              uart_rx_i,
   output logic              bus_req_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   input  logic              wr_ready_i,
   output logic              frame_err_o,
   output logic              overrun_err_o,
   output logic [15:0]       word_cnt_o
);

   localparam int NB     = DATA_W / 8;
   localparam int BC_W   = $clog2(NB + 1);
   localparam int TO_CYC = TIMEOUT_BITS * baud_div(CLK_FREQ, BAUD);
   localparam int TO_W   = $clog2(TO_CYC + 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(NB);

   logic              en_sync, rx_idle, rx_valid, rx_ferr;
   logic [7:0]        rx_byte;
   logic [DATA_W-1:0] partial, word_next;
   logic [BC_W-1:0]   byte_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              word_done, to_hit;

   uart_rx_core #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD        (BAUD),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en_i),
      .uart_rx_i    (uart_rx_i),
      .en_sync_o    (en_sync),
      .idle_o       (rx_idle),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_ferr)
   );

   always_comb begin
      word_next = partial;
      word_next[8*byte_cnt +: 8] = rx_byte;
   end

   assign word_done = rx_valid && (byte_cnt == BC_W'(NB - 1));
   assign to_hit    = (to_cnt == TO_W'(TO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req_o     <= 1'b0;
         wr_en_o       <= 1'b0;
         wr_addr_o     <= BASE_ADDR;
         wr_data_o     <= '0;
         frame_err_o   <= 1'b0;
         overrun_err_o <= 1'b0;
         word_cnt_o    <= '0;
         partial       <= '0;
         byte_cnt      <= '0;
         to_cnt        <= '0;
      end else begin
         bus_req_o <= en_sync;
         if (!en_sync) begin
            wr_en_o       <= 1'b0;
            wr_addr_o     <= BASE_ADDR;
            wr_data_o     <= '0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
            word_cnt_o    <= '0;
            partial       <= '0;
            byte_cnt      <= '0;
            to_cnt        <= '0;
         end else begin
            if (wr_en_o && wr_ready_i) begin
               wr_en_o    <= 1'b0;
               wr_addr_o  <= wr_addr_o + ADDR_STEP;
               word_cnt_o <= word_cnt_o + 16'd1;
            end
            if (rx_ferr) begin
               frame_err_o <= 1'b1;
               byte_cnt    <= '0;
            end else if (rx_valid) begin
               if (word_done) begin
                  byte_cnt <= '0;
                  // A word completing on top of a pending write is dropped; the pending one stands.
                  if (wr_en_o) begin
                     overrun_err_o <= 1'b1;
                  end else begin
                     wr_en_o   <= 1'b1;
                     wr_data_o <= word_next;
                  end
               end else begin
                  partial  <= word_next;
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end else if (to_hit) begin
               byte_cnt <= '0;
            end
            // Timer only runs while idle between bytes of a partially assembled word.
            if (!rx_idle || byte_cnt == '0 || to_hit) to_cnt <= '0;
            else                                      to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/uart_loader.md
# uart_loader

Parametrised UART program loader: the successor to the fixed 19200-baud, 32-bit debug downloader. It receives a raw byte stream on a UART line and packs it little-endian into DATA_W-bit words. Each word is written to instruction/data memory at consecutive addresses from BASE_ADDR through a ready/valid write port. It sits between the board UART pin and the RIB bus master mux, and adds start-bit glitch rejection, stop-bit checking, inter-byte timeout resynchronisation, bus back-pressure and error/status reporting.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 19200, UART bit rate
- ADDR_W, 32, write-address width
- DATA_W, 32, write-data width; must be a multiple of 8, minimum 8
- BASE_ADDR, 0, address of the first word written after enable
- SYNC_STAGES, 2, synchroniser depth for uart_rx_i and en_i; minimum 2
- TIMEOUT_BITS, 64, idle bit-periods after which a partial word is discarded
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  loader enable, asynchronous (switch/key)
- uart_rx_i  in  1  UART line, idle high, asynchronous
- bus_req_o  out  1  bus ownership request; registered copy of the synchronised en_i
- wr_en_o  out  1  write valid
- wr_addr_o  out  ADDR_W  write address
- wr_data_o  out  DATA_W  write data
- wr_ready_i  in  1  write accepted when high together with wr_en_o
- frame_err_o  out  1  sticky: a stop bit was sampled low
- overrun_err_o  out  1  sticky: a word completed while the previous write was still pending
- word_cnt_o  out  16  number of accepted writes since enable; wraps modulo 2^16

## Operation
- Reset and synchronised en_i low both clear all state: outputs go to 0, except wr_addr_o, which goes to BASE_ADDR.
- Receive FSM:
  - IDLE -> START on a falling edge of the synchronised rx.
  - START: at mid-bit (count DIV/2-1), if rx is still low go to DATA; otherwise return to IDLE (glitch rejected).
  - DATA: 8 bits, each sampled at mid-bit, LSB first.
  - STOP: sampled at mid-bit. If high, the byte is valid. If low, set frame_err_o, discard the byte and clear the partial word.
  - STOP -> IDLE right after the stop sample, so back-to-back frames are supported.
- Word assembly: the k-th byte of a word goes to bits [8k+7:8k]. After DATA_W/8 valid bytes, the word moves to the output holding register.
- Write handshake:
  - wr_en_o rises with wr_addr_o and wr_data_o.
  - All three hold stable until a cycle with wr_en_o && wr_ready_i.
  - In the cycle after acceptance: wr_en_o falls, wr_addr_o += DATA_W/8 (wraps at 2^ADDR_W), word_cnt_o increments.
- Overrun: if a new word completes while wr_en_o is still high, set overrun_err_o and drop the new word. The pending write is unaffected.
- Timeout:
  - Applies only with 1..DATA_W/8-1 bytes buffered and the FSM in IDLE.
  - After TIMEOUT_BITS*DIV cycles with no start bit, the partial word is discarded.
  - The timer restarts on every start bit.
- en_i falling mid-frame or mid-handshake is an abort: everything clears at once, and any pending write is dropped.

## Timing
- DIV = CLK_FREQ/BAUD, integer floor. Baud counter width is $clog2(DIV).
- Input latency: SYNC_STAGES cycles from a pin edge to the FSM.
- The FSM sees en_i after SYNC_STAGES cycles; bus_req_o follows one cycle later.
- Last stop-bit sample to wr_en_o high: 1 cycle.
- wr_ready_i held high gives a one-cycle write pulse.
- Error flags set in the cycle after the offending sample. They clear only on reset or when en_i goes low.

## Structure
- Shared defines header holds CLK_FREQ, UART_BPS and the address/data bus widths. These are used as top-level parameter overrides.
- FSM state encodings are localparams inside the block.
- Sub-module uart_rx_core contains the synchroniser, baud counter, receive FSM and frame check. It outputs byte_o, byte_valid_o and frame_err_o.
- uart_loader contains word assembly, timeout, the write port and the counters.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), DATA_W=32, BASE_ADDR=0x100, TIMEOUT_BITS=8.
- Send bytes 0x13,0x05,0x00,0x00 back-to-back with wr_ready_i=1 -> one pulse with wr_addr_o=0x100, wr_data_o=0x00000513; then wr_addr_o=0x104, word_cnt_o=1.
- Send 8 bytes with wr_ready_i held low for 200 cycles after the first word -> wr_en_o/addr/data stay stable until ready; both words are written, at 0x100 and 0x104; no overrun.
- Hold wr_ready_i low through two full words -> overrun_err_o=1; only the first word is written after ready rises.
- 3-cycle low glitch on rx -> no byte received, no error. Byte with stop bit forced low -> frame_err_o=1, no write.
- Send 2 bytes, then idle 100 cycles, then 4 bytes 0xAA,0xBB,0xCC,0xDD -> one write of 0xDDCCBBAA at 0x100.
- Drop en_i after 2 bytes of a word -> within SYNC_STAGES+1 cycles all outputs are 0 and wr_addr_o=0x100. Re-enable and send 4 bytes -> write at 0x100.
